// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width, state encoding and counter sizing for the serial adder
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(ALU_WIDTH);

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit combinational full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu_adder.sv
// rtl/serial_alu_adder.sv - LSB-first bit-serial adder with registered sum and flags
module serial_alu_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] AMod,
    input  logic [WIDTH-1:0] BMod,
    input  logic [2:0]       Op,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic [2:0]       OpOut
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic             r_amsb;
    logic             r_bmsb;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic [2:0]       r_op_out;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Sum bits enter at the MSB so the word is LSB-aligned once WIDTH bits are in.
    assign w_res_next = {w_sum, r_res};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_amsb      <= 1'b0;
            r_bmsb      <= 1'b0;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_op_out    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (InValid) begin
                        r_a     <= AMod;
                        r_b     <= BMod;
                        r_op    <= Op;
                        r_amsb  <= AMod[WIDTH-1];
                        r_bmsb  <= BMod[WIDTH-1];
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next[WIDTH-1:1];
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        // Overflow uses the operand MSBs latched at acceptance.
                        r_s         <= w_res_next;
                        r_c         <= w_cout;
                        r_z         <= (w_res_next == '0);
                        r_n         <= w_sum;
                        r_v         <= (r_amsb == r_bmsb) && (w_sum != r_amsb);
                        r_op_out    <= r_op;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign InReady  = (r_state == ST_IDLE) && !reset;
    assign OutValid = r_out_valid;
    assign S        = r_s;
    assign C        = r_c;
    assign Z        = r_z;
    assign N        = r_n;
    assign V        = r_v;
    assign OpOut    = r_op_out;

endmodule

// File: tb/tb_serial_alu_adder.sv
// tb/tb_serial_alu_adder.sv - scoreboard bench for the bit-serial adder
module tb_serial_alu_adder;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
        logic [2:0]   op;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] AMod = '0;
    logic [W-1:0] BMod = '0;
    logic [2:0]   Op = '0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [W-1:0] S;
    logic         C, Z, N, V;
    logic [2:0]   OpOut;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_hs = 0;
    bit   rand_ready = 0;
    logic prev_ov = 1'b0;
    exp_t q[$];

    serial_alu_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .AMod     (AMod),
        .BMod     (BMod),
        .Op       (Op),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .S        (S),
        .C        (C),
        .Z        (Z),
        .N        (N),
        .V        (V),
        .OpOut    (OpOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   sum, sa, sb, ss;
        sum  = a + b;
        sa   = (a >= 8) ? a - 16 : a;
        sb   = (b >= 8) ? b - 16 : b;
        ss   = sa + sb;
        e.s  = W'(sum % 16);
        e.c  = (sum >= 16);
        e.z  = ((sum % 16) == 0);
        e.n  = ((sum % 16) >= 8);
        e.v  = (ss > 7) || (ss < -8);
        e.op = 3'(op);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: compare every output handshake against the queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (OutValid && !prev_ov && q.size() > 0)
                chk("latency", cyc, q[0].acc + W);
            if (OutValid && OutReady) begin
                last_hs = cyc + 1;
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("S", int'(S), int'(e.s));
                    chk("C", int'(C), int'(e.c));
                    chk("Z", int'(Z), int'(e.z));
                    chk("N", int'(N), int'(e.n));
                    chk("V", int'(V), int'(e.v));
                    chk("OpOut", int'(OpOut), int'(e.op));
                end
            end
            prev_ov = OutValid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 OutReady = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input bit hold, output int acc);
        int   n;
        exp_t e;
        n = 0;
        acc = -1;
        @(negedge clk);
        InValid = 1'b1;
        AMod = a;
        BMod = b;
        Op = op;
        while (!InReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            chk("send_timeout", 0, 1);
            InValid = 1'b0;
        end else begin
            e = model(int'(a), int'(b), int'(op));
            acc = cyc + 1;
            e.acc = acc;
            q.push_back(e);
            @(posedge clk);
            if (!hold) #1 InValid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || OutValid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(q.size() != 0 || OutValid), 0);
    endtask

    initial begin
        int acc, acc2, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_inready", int'(InReady), 0);
        chk("rst_outvalid", int'(OutValid), 0);
        chk("rst_S", int'(S), 0);
        chk("rst_flags", int'({C, Z, N, V}), 0);
        chk("rst_opout", int'(OpOut), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_inready", int'(InReady), 1);

        // Directed: 0011 + 0101
        send(4'b0011, 4'b0101, 3'b000, 0, acc);
        wait_drain();
        chk("t1_S_hold", int'(S), 8);
        chk("t1_CZNV", int'({C, Z, N, V}), 4'b0011);

        // Directed: 1111 + 0001, op 101
        send(4'b1111, 4'b0001, 3'b101, 0, acc);
        wait_drain();
        chk("t2_S_hold", int'(S), 0);
        chk("t2_CZNV", int'({C, Z, N, V}), 4'b1100);
        chk("t2_opout", int'(OpOut), 5);

        // Backpressure: OutReady low for 3 cycles while result is held
        @(posedge clk);
        #1 OutReady = 1'b0;
        send(4'b0010, 4'b0011, 3'b011, 0, acc);
        n = 0;
        while (!OutValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_outvalid", int'(OutValid), 1);
            chk("bp_S", int'(S), 5);
            chk("bp_inready", int'(InReady), 0);
        end
        @(posedge clk);
        #1 OutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_inready", int'(InReady), 1);
        chk("bp_outvalid_fall", int'(OutValid), 0);
        wait_drain();

        // Reset abort after 2 SHIFT edges
        send(4'b0110, 4'b0110, 3'b010, 0, acc);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        chk("abort_outvalid", int'(OutValid), 0);
        chk("abort_S", int'(S), 0);
        chk("abort_flags", int'({C, Z, N, V}), 0);
        chk("abort_opout", int'(OpOut), 0);
        chk("abort_inready_rst", int'(InReady), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_inready_rel", int'(InReady), 1);
        repeat (8) @(negedge clk);
        chk("abort_no_out", int'(OutValid), 0);

        // Back-to-back with InValid held high
        send(4'b0001, 4'b0001, 3'b001, 1, acc);
        send(4'b1000, 4'b1000, 3'b110, 1, acc2);
        chk("b2b_gap", acc2, last_hs + 1);
        @(negedge clk);
        InValid = 1'b0;
        wait_drain();
        chk("b2b_S", int'(S), 0);
        chk("b2b_CZV", int'({C, Z, V}), 3'b111);

        // Randomized operands with random downstream stalls
        rand_ready = 1;
        for (int i = 0; i < 25; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 0, acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();
        rand_ready = 0;
        @(posedge clk);
        #1 OutReady = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
